// File: rtl/alu_pkg.sv
// Shared definitions for the stack ALU and its command sequencer.
//   OP_*        3-bit ALU opcodes
//   ERR_*       2-bit error codes reported by the sequencer
//   seq_state_t sequencer FSM states
//   op_is_legal opcode legality check (does not consider stack depth)
package alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_RUN,
    ST_ERROR
  } seq_state_t;

  // 001/010/011 are the only undefined encodings.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_NOP) || op[2];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head output.
//   clk, rst   clock / asynchronous active-high reset (flushes pointers)
//   push       write wdata this edge (caller guarantees !full)
//   pop        discard head this edge (caller guarantees !empty)
//   wdata      W-bit entry to write
//   full/empty occupancy flags
//   head       current head entry
module cmd_fifo #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty when the
  // index bits coincide.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  w_one;

  assign w_one = {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + w_one;
      if (pop)  r_rd_ptr <= r_rd_ptr + w_one;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Upstream feeder for the stack ALU. Buffers {opcode,data} commands,
// issues at most one per cycle on registered ALU pins, tracks the ALU
// stack depth and parks in ERROR on any command that would underflow,
// overflow or is illegal.
//   clk, rst              clock / asynchronous active-high reset
//   in_valid/in_ready     command handshake; in_opcode, in_data payload
//   hold                  suppress issue (FIFO still accepts)
//   err_clear             drop the offending head and return to RUN
//   alu_opcode, alu_data  registered ALU drive
//   depth                 tracked ALU stack occupancy
//   err, err_code         error flag and cause (01 under, 10 over, 11 illegal)
//   busy                  FIFO non-empty or an issue in flight
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned STACK_SIZE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_opcode,
  input  logic [N-1:0]                  in_data,
  input  logic                          hold,
  input  logic                          err_clear,
  output logic [2:0]                    alu_opcode,
  output logic [N-1:0]                  alu_data,
  output logic [$clog2(STACK_SIZE+1)-1:0] depth,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic                          busy
);

  localparam int unsigned DW = $clog2(STACK_SIZE + 1);
  localparam int unsigned CW = 3 + N;

  seq_state_t      r_state, w_state_nxt;
  logic [1:0]      r_err_code, w_err_code_nxt;
  logic [DW-1:0]   r_depth, w_depth_nxt;
  logic [2:0]      r_alu_opcode, w_alu_opcode_nxt;
  logic [N-1:0]    r_alu_data, w_alu_data_nxt;
  logic            r_inflight, w_issue;

  logic            w_push, w_pop, w_full, w_empty;
  logic [CW-1:0]   w_head;
  logic [2:0]      w_head_op;
  logic [N-1:0]    w_head_data;
  logic [1:0]      w_chk;
  logic [DW-1:0]   w_dmax, w_one, w_two;

  assign w_dmax = DW'(STACK_SIZE);
  assign w_one  = DW'(1);
  assign w_two  = DW'(2);

  cmd_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({in_opcode, in_data}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign w_head_op   = w_head[CW-1:N];
  assign w_head_data = w_head[N-1:0];

  assign in_ready = !w_full && (r_state == ST_RUN);
  assign w_push   = in_valid && in_ready;

  // Legality of the head command against the current depth.
  always_comb begin
    w_chk = ERR_NONE;
    if (!op_is_legal(w_head_op)) begin
      w_chk = ERR_ILLEGAL;
    end else begin
      case (w_head_op)
        OP_ADD, OP_MUL: if (r_depth < w_two)   w_chk = ERR_UNDER;
        OP_POP:         if (r_depth < w_one)   w_chk = ERR_UNDER;
        OP_PUSH:        if (r_depth >= w_dmax) w_chk = ERR_OVER;
        default:        w_chk = ERR_NONE;
      endcase
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_err_code_nxt   = r_err_code;
    w_depth_nxt      = r_depth;
    w_alu_opcode_nxt = OP_NOP;
    w_alu_data_nxt   = '0;
    w_pop            = 1'b0;
    w_issue          = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!hold && !w_empty) begin
          if (w_chk == ERR_NONE) begin
            w_pop            = 1'b1;
            w_issue          = 1'b1;
            w_alu_opcode_nxt = w_head_op;
            w_alu_data_nxt   = w_head_data;
            case (w_head_op)
              OP_PUSH:                w_depth_nxt = r_depth + w_one;
              OP_ADD, OP_MUL, OP_POP: w_depth_nxt = r_depth - w_one;
              default:                w_depth_nxt = r_depth;
            endcase
          end else begin
            w_state_nxt    = ST_ERROR;
            w_err_code_nxt = w_chk;
          end
        end
      end
      ST_ERROR: begin
        if (err_clear) begin
          w_pop          = 1'b1;
          w_state_nxt    = ST_RUN;
          w_err_code_nxt = ERR_NONE;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_err_code   <= ERR_NONE;
      r_depth      <= '0;
      r_alu_opcode <= OP_NOP;
      r_alu_data   <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_err_code   <= w_err_code_nxt;
      r_depth      <= w_depth_nxt;
      r_alu_opcode <= w_alu_opcode_nxt;
      r_alu_data   <= w_alu_data_nxt;
      r_inflight   <= w_issue;
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_data   = r_alu_data;
  assign depth      = r_depth;
  assign err        = (r_state == ST_ERROR);
  assign err_code   = r_err_code;
  assign busy       = !w_empty || r_inflight;

endmodule
